// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared funct3 encodings, FSM state type and request checker
//             for the lsu_rmw load/store unit.
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // True when the request must be answered with an error and no RAM access:
  // an illegal funct3 for the direction, or a size/offset misalignment.
  function automatic logic req_bad(input logic we, input logic [2:0] funct3,
                                   input logic [1:0] off);
    logic illegal;
    logic misaligned;
    if (we) illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW});
    else    illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    case (funct3)
      F3_LH, F3_LHU: misaligned = off[0];
      F3_LW:         misaligned = (off != 2'b00);
      default:       misaligned = 1'b0;
    endcase
    return illegal | misaligned;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Purpose  : Combinational lane logic: extracts and sign/zero-extends
//             sub-word load data, and merges store data into a RAM word.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte lane and halfword lane out of the RAM word
  always_comb begin
    case (off)
      2'd0:    sel_byte = mem_rdata[7:0];
      2'd1:    sel_byte = mem_rdata[15:8];
      2'd2:    sel_byte = mem_rdata[23:16];
      default: sel_byte = mem_rdata[31:24];
    endcase
    sel_half = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // Extend the selected lane to a full register value
  always_comb begin
    case (funct3)
      F3_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_LH:   load_data = {{16{sel_half[15]}}, sel_half};
      F3_LW:   load_data = mem_rdata;
      F3_LBU:  load_data = {24'd0, sel_byte};
      F3_LHU:  load_data = {16'd0, sel_half};
      default: load_data = 32'd0;
    endcase
  end

  // Replace only the target lanes of the old word with the store data
  always_comb begin
    merge_data = mem_rdata;
    case (funct3)
      F3_LB: begin
        case (off)
          2'd0:    merge_data[7:0]   = wdata[7:0];
          2'd1:    merge_data[15:8]  = wdata[7:0];
          2'd2:    merge_data[23:16] = wdata[7:0];
          default: merge_data[31:24] = wdata[7:0];
        endcase
      end
      F3_LH: begin
        if (off[1]) merge_data[31:16] = wdata[15:0];
        else        merge_data[15:0]  = wdata[15:0];
      end
      F3_LW:   merge_data = wdata;
      default: merge_data = mem_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_rmw.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_rmw
//  Purpose  : RV32I load/store unit for a word-addressed RAM. Sub-word
//             stores are performed as read-modify-write; the RAM strobe,
//             address and write data all come straight from registers.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int XLEN   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [XLEN-1:0]   i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  output logic              o_rsp_valid,
  output logic [XLEN-1:0]   o_rdata,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic              o_mem_wr,
  input  logic [XLEN-1:0]   i_mem_rdata
);

  state_t          state;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merge_data;

  // Byte-address bits above the RAM window are intentionally discarded (wrap)
  logic unused_addr_hi;
  assign unused_addr_hi = ^i_addr[XLEN-1:ADDR_W+2];

  assign o_req_ready = (state == IDLE);

  lsu_align u_align (
    .funct3     (funct3_q),
    .off        (off_q),
    .mem_rdata  (i_mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Request sequencer: accept, settle address, optional write, respond
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      wdata_q     <= '0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_wr    <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_err       <= 1'b0;
      o_rdata     <= '0;
    end else begin
      o_rsp_valid <= 1'b0;
      o_err       <= 1'b0;
      o_mem_wr    <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            we_q       <= i_we;
            funct3_q   <= i_funct3;
            off_q      <= i_addr[1:0];
            wdata_q    <= i_wdata;
            // Only place the RAM address ever changes
            o_mem_addr <= i_addr[ADDR_W+1:2];
            if (req_bad(i_we, i_funct3, i_addr[1:0])) begin
              o_rsp_valid <= 1'b1;
              o_err       <= 1'b1;
              o_rdata     <= '0;
              state       <= RESP;
            end else begin
              state <= ADDR;
            end
          end
        end
        ADDR: begin
          // Address has been stable for a full cycle; RAM data is valid
          if (we_q) begin
            o_mem_wdata <= merge_data;
            o_mem_wr    <= 1'b1;
            state       <= WRITE;
          end else begin
            o_rdata     <= load_data;
            o_rsp_valid <= 1'b1;
            state       <= RESP;
          end
        end
        WRITE: begin
          o_rdata     <= '0;
          o_rsp_valid <= 1'b1;
          state       <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_rmw.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_rmw
//  Purpose  : Self-checking bench for lsu_rmw with a RAM model and a
//             byte-level reference memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_rmw;

  localparam int ADDR_W = 13;
  localparam int NWORDS = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              we;
  logic [2:0]        funct3;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              rsp_valid;
  logic [31:0]       rdata;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_wr;
  logic [31:0]       mem_rdata;

  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [31:0]       pl_data;

  logic [31:0] ram     [NWORDS];
  logic [31:0] ref_mem [NWORDS];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_rmw #(.ADDR_W(ADDR_W), .XLEN(32)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_we        (we),
    .i_funct3    (funct3),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_rsp_valid (rsp_valid),
    .o_rdata     (rdata),
    .o_err       (err),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_wr    (mem_wr),
    .i_mem_rdata (mem_rdata)
  );

  // RAM: combinational read, write while strobe is high at the clock edge
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (mem_wr)     ram[mem_addr] <= mem_wdata;
    else if (pl_en) ram[pl_addr]  <= pl_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_err(input logic q_we, input int f3, input int off);
    bit legal;
    int size;
    legal = q_we ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
    size  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    return !legal || (off % size != 0);
  endfunction

  function automatic logic [31:0] model_load(input int f3, input logic [31:0] word, input int off);
    longint v;
    v = longint'(word >> (8 * off));
    case (f3)
      0: begin v = v % 256;   if (v >= 128)   v -= 256;   end
      1: begin v = v % 65536; if (v >= 32768) v -= 65536; end
      4: v = v % 256;
      5: v = v % 65536;
      default: v = longint'(word);
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_store(input int f3, input logic [31:0] old,
                                              input int off, input logic [31:0] wd);
    logic [7:0] b [4];
    int n;
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    n = 1 << f3;
    for (int i = 0; i < n; i++) b[off + i] = wd[8*i +: 8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic preload(input int w, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = ADDR_W'(w); pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
    ref_mem[w] = d;
  endtask

  // One request: drive, then watch every cycle until the response
  task automatic do_req(input logic q_we, input logic [2:0] q_f3, input logic [31:0] q_addr,
                        input logic [31:0] q_wd, input string tag, output logic [31:0] got);
    int w, off, exp_lat, lat, wr_cnt, wr_cyc;
    logic e, addr_ok, busy_ok, got_err;
    logic [31:0] exp_rd, exp_word, wr_data;
    w   = int'(q_addr[ADDR_W+1:2]);
    off = int'(q_addr[1:0]);
    e   = model_err(q_we, int'(q_f3), off);
    exp_rd   = 32'd0;
    exp_word = ref_mem[w];
    if (e)         exp_lat = 1;
    else if (q_we) begin exp_lat = 3; exp_word = model_store(int'(q_f3), ref_mem[w], off, q_wd); end
    else           begin exp_lat = 2; exp_rd = model_load(int'(q_f3), ref_mem[w], off); end

    @(negedge clk);
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; we = q_we; funct3 = q_f3; addr = q_addr; wdata = q_wd;
    @(posedge clk);
    #1;
    // Keep a different request asserted while busy; it must be ignored
    we = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    lat = 0; wr_cnt = 0; wr_cyc = 0; addr_ok = 1'b1; busy_ok = 1'b1;
    wr_data = 32'd0; got = 32'hxxxx_xxxx; got_err = 1'bx;
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      @(negedge clk);
      if (mem_addr !== q_addr[ADDR_W+1:2]) addr_ok = 1'b0;
      if (req_ready !== 1'b0) busy_ok = 1'b0;
      if (mem_wr === 1'b1) begin wr_cnt++; wr_cyc = k; wr_data = mem_wdata; end
      if (rsp_valid === 1'b1) begin
        lat = k; got = rdata; got_err = err;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;

    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " err"}, 32'(got_err), 32'(e));
    check({tag, " rdata"}, got, exp_rd);
    check({tag, " wr pulses"}, 32'(wr_cnt), (q_we && !e) ? 32'd1 : 32'd0);
    check({tag, " addr stable"}, 32'(addr_ok), 32'd1);
    check({tag, " busy not ready"}, 32'(busy_ok), 32'd1);
    if (q_we && !e) begin
      check({tag, " wr cycle"}, 32'(wr_cyc), 32'd2);
      check({tag, " wr data"}, wr_data, exp_word);
    end
    check({tag, " ram word"}, ram[w], exp_word);
    ref_mem[w] = exp_word;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] got;
    logic [2:0]  tp_f3  [6];
    logic [31:0] tp_adr [6];
    logic [31:0] tp_exp [6];
    logic [31:0] exp_w;
    logic [31:0] r_addr;

    rst = 1'b1; req_valid = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    pl_en = 1'b0; pl_addr = '0; pl_data = 32'd0;
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = 32'd0;
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset mem_wr", 32'(mem_wr), 32'd0);
    check("reset mem_addr", 32'(mem_addr), 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    check("reset rdata", rdata, 32'd0);

    // Loads from a known word, each against a hand-computed value
    preload(5, 32'h8070_60F0);
    tp_f3[0] = 3'd0; tp_adr[0] = 32'h16; tp_exp[0] = 32'h0000_0070;
    tp_f3[1] = 3'd0; tp_adr[1] = 32'h14; tp_exp[1] = 32'hFFFF_FFF0;
    tp_f3[2] = 3'd4; tp_adr[2] = 32'h14; tp_exp[2] = 32'h0000_00F0;
    tp_f3[3] = 3'd1; tp_adr[3] = 32'h16; tp_exp[3] = 32'hFFFF_8070;
    tp_f3[4] = 3'd5; tp_adr[4] = 32'h16; tp_exp[4] = 32'h0000_8070;
    tp_f3[5] = 3'd2; tp_adr[5] = 32'h14; tp_exp[5] = 32'h8070_60F0;
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, tp_f3[i], tp_adr[i], 32'd0, $sformatf("load%0d", i), got);
      check($sformatf("load%0d value", i), got, tp_exp[i]);
    end

    // Sub-word and word stores
    preload(5, 32'h1122_3344);
    do_req(1'b1, 3'd0, 32'h15, 32'hFFFF_FFAB, "sb", got);
    check("sb mem5", ram[5], 32'h1122_AB44);
    preload(5, 32'h1122_3344);
    do_req(1'b1, 3'd1, 32'h16, 32'h1234_BEEF, "sh", got);
    do_req(1'b1, 3'd2, 32'h20, 32'hDEAD_BEEF, "sw", got);
    check("sh mem5", ram[5], 32'hBEEF_3344);
    check("sw mem8", ram[8], 32'hDEAD_BEEF);

    // Erroring requests
    do_req(1'b0, 3'd2, 32'h13, 32'd0, "lw misaligned", got);
    do_req(1'b1, 3'd1, 32'h15, 32'h5555_5555, "sh misaligned", got);
    do_req(1'b0, 3'd3, 32'h14, 32'd0, "load f3=3", got);
    do_req(1'b1, 3'd4, 32'h14, 32'h7777_7777, "store f3=4", got);

    // Reset asserted during the WRITE cycle of a byte store
    preload(9, 32'hA1B2_C3D4);
    exp_w = model_store(0, ref_mem[9], 1, 32'h0000_005A);
    @(negedge clk);
    req_valid = 1'b1; we = 1'b1; funct3 = 3'd0; addr = 32'h25; wdata = 32'h0000_005A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rst-sb addr cycle wr", 32'(mem_wr), 32'd0);
    @(negedge clk);
    check("rst-sb write cycle wr", 32'(mem_wr), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst-sb wr after reset", 32'(mem_wr), 32'd0);
    check("rst-sb no rsp", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst-sb ready after", 32'(req_ready), 32'd1);
    check("rst-sb still no rsp", 32'(rsp_valid), 32'd0);
    ref_mem[9] = exp_w;
    check("rst-sb ram word", ram[9], exp_w);
    do_req(1'b0, 3'd2, 32'h24, 32'd0, "rst-sb lw", got);
    check("rst-sb lw value", got, exp_w);

    // Randomised traffic, including wrapped upper address bits
    for (int i = 0; i < 40; i++) begin
      r_addr = ($urandom & 32'hFFFF_8000) | 32'($urandom_range(0, 127));
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), r_addr, $urandom,
             $sformatf("rand%0d", i), got);
    end

    for (int i = 0; i < 64; i++) begin
      if (ram[i] !== ref_mem[i]) check($sformatf("final word %0d", i), ram[i], ref_mem[i]);
    end
    check("final word 5", ram[5], ref_mem[5]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store unit between the RV32I datapath and the word-addressed data RAM (13-bit word address, 32-bit data, combinational read, level-sensitive write).
- Converts byte, halfword and word loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into RAM word accesses.
- Sub-word loads are extracted and sign- or zero-extended.
- Sub-word stores are done as a read-modify-write sequence.
- Drives the RAM write strobe only from registers, with the address held stable around every write.

Parameters:
- ADDR_W, 13, RAM word-address width; the byte address is i_addr[ADDR_W+1:0].
- XLEN, 32, data width; only 32 is supported.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  high only in IDLE
- i_we  in  1  1 = store, 0 = load
- i_funct3  in  3  RV32I load/store funct3
- i_addr  in  32  byte address
- i_wdata  in  32  store data, LSB-aligned
- o_rsp_valid  out  1  one-cycle completion pulse
- o_rdata  out  32  extended load data; 0 for stores and errors
- o_err  out  1  misaligned access or illegal funct3, qualified by o_rsp_valid
- o_mem_addr  out  ADDR_W  RAM word address (registered)
- o_mem_wdata  out  32  RAM write data (registered)
- o_mem_wr  out  1  RAM write enable (registered)
- i_mem_rdata  in  32  RAM read data (combinational from o_mem_addr)

Behaviour:
- Reset: state = IDLE. o_req_ready = 1 from the first cycle after reset. o_rsp_valid, o_err, o_mem_wr, o_mem_addr, o_mem_wdata, o_rdata all 0.
- Accept: on i_req_valid & o_req_ready at edge N, latch i_we, i_funct3, i_addr[1:0], i_wdata. Load o_mem_addr <= i_addr[ADDR_W+1:2]; upper address bits are ignored (wrap).
- Request checks at accept:
  - Legal loads: funct3 0, 1, 2, 4, 5.
  - Legal stores: funct3 0, 1, 2.
  - Halfword with addr[0] = 1 is misaligned.
  - Word with addr[1:0] != 0 is misaligned.
  - Misaligned or illegal funct3: go to RESP (o_rsp_valid, o_err = 1, o_rdata = 0 at cycle N+1). No RAM access.
- FSM:
  - IDLE -> ADDR on a good request; IDLE -> RESP on an erroring request.
  - ADDR: o_mem_wr = 0 and the address settles.
    - Load: register the extended result from i_mem_rdata, then -> RESP.
    - Store: merge = i_mem_rdata with the target byte/halfword lanes replaced by i_wdata[7:0] / i_wdata[15:0] (SW replaces all lanes). Register merge into o_mem_wdata, then -> WRITE.
  - WRITE: o_mem_wr = 1 for exactly this cycle; o_mem_addr and o_mem_wdata are unchanged. -> RESP.
  - RESP: o_rsp_valid = 1 for one cycle, o_mem_wr = 0, o_mem_addr held. -> IDLE.
- Latency from accept edge N:
  - load response at N+2
  - store response at N+3
  - error response at N+1
  - next accept possible on the edge after RESP (throughput 1 request per 3 or 4 cycles)
- Lane selection: byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend from bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
- Write-strobe rules:
  - o_mem_addr changes only on the IDLE-accept edge.
  - o_mem_wr is never high in the cycle o_mem_addr changes, nor in the cycle after.
- o_rdata holds its value until the next response.
- i_req_valid while not ready is ignored; the requester holds its request.
- Reset mid-operation: synchronous reset returns the FSM to IDLE and clears o_mem_wr on that edge. An in-flight store is either fully written (reset after WRITE) or not written at all. No response is issued for the aborted request.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_LB=0, F3_LH=1, F3_LW=2, F3_LBU=4, F3_LHU=5
  - FSM state encoding: IDLE, ADDR, WRITE, RESP
- One natural sub-module, lsu_align: purely combinational load extract/extend and store lane merge. The FSM and registers stay in lsu_rmw.

Test Plan:
- Preload mem[5] = 0x8070_60F0. LB at 0x16 (lane 2) -> rsp at N+2, o_rdata = 0x0000_0070. LB at 0x14 -> 0xFFFF_FFF0. LBU at 0x14 -> 0x0000_00F0.
- LH at 0x16 -> 0xFFFF_8070. LHU at 0x16 -> 0x0000_8070. LW at 0x14 -> 0x8070_60F0.
- SB 0xAB at 0x15 on mem[5] = 0x1122_3344 -> single o_mem_wr pulse at N+2 with addr 5 and data 0x1122_AB44; rsp at N+3. Bench checks o_mem_addr is stable from N+1 to N+3.
- SH 0xBEEF at 0x16, then SW 0xDEADBEEF at 0x20 -> mem[5] = 0xBEEF_3344 and mem[8] = 0xDEAD_BEEF. Back-to-back requests are accepted only when o_req_ready is high.
- LW at 0x13, SH at 0x15, load with funct3 = 3 -> each gives o_err = 1 at N+1, o_rdata = 0, and no o_mem_wr pulse.
- Assert i_rst during WRITE of an SB -> o_mem_wr low on the next edge, no o_rsp_valid, o_req_ready = 1 the cycle after reset deasserts. A subsequent LW returns a consistent word.
